hazard_scoreboard: RTL

Parametrised, clocked successor to the ID-stage hazard detector. It holds a per-register countdown scoreboard of in-flight results, so it can stall for arbitrary producer latencies: ALU, load, and a multi-cycle multiplier. It also handles ID-resolved branches, a non-pipelined multiplier structural hazard, and a global pipeline hold. It sits beside the ID stage and drives the PC/IF-ID write-enable and the ID/EX bubble.

---
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID stage and the hazard scoreboard.
// master: ID-stage side, drives instruction fields, hold and stat_clear,
//         receives stall / flush_ex / issue / stall_count.
// slave : scoreboard side, the mirror image.
interface hazard_scoreboard_if #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic             hold;
   logic             id_valid;
   logic             id_flush;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [AW-1:0]    id_rs;
   logic [AW-1:0]    id_rt;
   logic             id_branch;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             id_mul;
   logic [AW-1:0]    id_rd;
   logic             stat_clear;
   logic             stall;
   logic             flush_ex;
   logic             issue;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output hold, id_valid, id_flush, id_use_rs, id_use_rt, id_rs, id_rt,
             id_branch, id_reg_write, id_mem_read, id_mul, id_rd, stat_clear,
      input  stall, flush_ex, issue, stall_count
   );

   modport slave (
      input  hold, id_valid, id_flush, id_use_rs, id_use_rt, id_rs, id_rt,
             id_branch, id_reg_write, id_mem_read, id_mul, id_rd, stat_clear,
      output stall, flush_ex, issue, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Clocked ID-stage hazard scoreboard.
// Keeps a per-register countdown of in-flight results and a multiplier
// occupancy counter; stalls the ID instruction while any source operand is
// not yet forwardable (threshold depends on EX vs ID-branch consumer) or the
// non-pipelined multiplier is busy.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - hazard_scoreboard_if.slave: ID instruction fields, hold,
//           stat_clear in; stall, flush_ex, issue, stall_count out
module hazard_scoreboard #(
   parameter int AW       = 5,
   parameter int ALU_LAT  = 0,
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 4,
   parameter int BR_EXTRA = 1,
   parameter int CNT_W    = 16
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);
   localparam int NREG    = 1 << AW;
   localparam int LAT_AL  = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
   localparam int LAT_MAX = (LAT_AL > MUL_LAT) ? LAT_AL : MUL_LAT;
   localparam int CW      = (LAT_MAX + BR_EXTRA > 0) ? $clog2(LAT_MAX + BR_EXTRA + 1) : 1;
   localparam int MW      = $clog2(MUL_LAT + 1);

   localparam logic [CW-1:0] ALU_VAL  = CW'(ALU_LAT + BR_EXTRA);
   localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT + BR_EXTRA);
   localparam logic [CW-1:0] MUL_VAL  = CW'(MUL_LAT + BR_EXTRA);
   localparam logic [MW-1:0] MDU_VAL  = MW'(MUL_LAT - 1);

   // cnt[0] is never loaded, so it stays at zero and r0 can never hazard.
   logic [CW-1:0]    cnt [NREG];
   logic [MW-1:0]    mduBusy;
   logic [CNT_W-1:0] stallCount;

   logic [31:0]      threshold;
   logic             rsHaz;
   logic             rtHaz;
   logic             mduHaz;
   logic             stallInt;
   logic             issueInt;
   logic [CW-1:0]    loadVal;

   // A branch compares in ID, one stage earlier than an EX consumer, so it
   // has to wait BR_EXTRA cycles longer: lower threshold.
   always_comb begin
      threshold = bus.id_branch ? 32'd0 : 32'(BR_EXTRA);
      rsHaz     = bus.id_use_rs && (bus.id_rs != '0) && (32'(cnt[bus.id_rs]) > threshold);
      rtHaz     = bus.id_use_rt && (bus.id_rt != '0) && (32'(cnt[bus.id_rt]) > threshold);
      mduHaz    = bus.id_mul && (mduBusy != '0);
      stallInt  = bus.id_valid && !bus.id_flush && (rsHaz || rtHaz || mduHaz);
      issueInt  = bus.id_valid && !bus.id_flush && !stallInt && !bus.hold;
   end

   always_comb begin
      if (bus.id_mem_read)
         loadVal = LOAD_VAL;
      else if (bus.id_mul)
         loadVal = MUL_VAL;
      else
         loadVal = ALU_VAL;
   end

   assign bus.stall       = stallInt;
   assign bus.flush_ex    = stallInt || bus.id_flush;
   assign bus.issue       = issueInt;
   assign bus.stall_count = stallCount;

   // Decrement everything, then let a fresh issue overwrite its rd so the
   // newest producer latency always wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++)
            cnt[r] <= '0;
         mduBusy <= '0;
      end else if (!bus.hold) begin
         for (int r = 0; r < NREG; r++)
            if (cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
         if (issueInt && bus.id_reg_write && (bus.id_rd != '0))
            cnt[bus.id_rd] <= loadVal;
         if (issueInt && bus.id_mul)
            mduBusy <= MDU_VAL;
         else if (mduBusy != '0)
            mduBusy <= mduBusy - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stallCount <= '0;
      else if (bus.stat_clear)
         stallCount <= '0;
      else if (!bus.hold && stallInt && (stallCount != '1))
         stallCount <= stallCount + 1'b1;
   end
endmodule
